line_clear: RTL and testbench

Row-elimination engine for the Tetris playfield. It sits directly upstream of the float/static merge stage and the display. When a falling piece locks, game control hands it the static board with the piece already merged in. This block finds every completely filled row, collapses the rows above it downward, and returns the compacted static board with the per-drop and running line counts.

---
 rtl/tetris_pkg.sv | 23 ++
 rtl/row_collapse.sv | 38 +++
 rtl/line_clear.sv | 111 +++++++++++
 tb/tb_line_clear.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris playfield definitions used by line_clear, merge and display.
// Board bit index convention: bit COLS*row + col, row 0 is the bottom row,
// on a vector declared [0:BOARD_BITS-1]; 1 = occupied cell.
package tetris_pkg;

  localparam int ROWS       = 20;
  localparam int COLS       = 10;
  localparam int BOARD_BITS = ROWS * COLS;
  localparam int TOTAL_MAX  = 999;
  localparam int LINES_W    = 5;
  localparam int TOTAL_W    = 10;

  // Line-clear engine state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Flat bit position of a (row, col) cell
  function automatic int bit_index(input int row, input int col);
    return COLS * row + col;
  endfunction

endpackage

// File: rtl/row_collapse.sv
// Combinational row test and collapse for one row pointer r.
// row_full reports whether row r of w is completely occupied; shifted is w
// with row r removed: rows below r unchanged, rows r..ROWS-2 take the row
// above, and the top row becomes empty.
module row_collapse #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int RW   = 5
) (
  input  logic [0:ROWS*COLS-1] w,
  input  logic [RW-1:0]        r,
  output logic                 row_full,
  output logic [0:ROWS*COLS-1] shifted
);

  logic [ROWS-1:0] full_vec;
  logic [ROWS-1:0] sel_vec;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi = gi + 1) begin : g_row
      assign full_vec[gi] = &w[gi*COLS +: COLS];
      assign sel_vec[gi]  = (r == RW'(gi));
      if (gi == ROWS - 1) begin : g_top
        // Top row is refilled with an empty row whenever it is at or above r
        assign shifted[gi*COLS +: COLS] =
          (RW'(gi) < r) ? w[gi*COLS +: COLS] : '0;
      end else begin : g_mid
        assign shifted[gi*COLS +: COLS] =
          (RW'(gi) < r) ? w[gi*COLS +: COLS] : w[(gi+1)*COLS +: COLS];
      end
    end
  endgenerate

  // Pointer values outside 0..ROWS-1 select no row and never report full
  assign row_full = |(full_vec & sel_vec);

endmodule

// File: rtl/line_clear.sv
// Row-elimination engine: on start, copies the locked board into a working
// register, tests one row per cycle from the bottom, collapses every full
// row, and publishes the compacted board with per-drop and running counts.
module line_clear #(
  parameter int ROWS      = 20,
  parameter int COLS      = 10,
  parameter int TOTAL_MAX = 999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [0:ROWS*COLS-1] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [0:ROWS*COLS-1] board_out,
  output logic [4:0]           lines,
  output logic [9:0]           total
);

  import tetris_pkg::*;

  localparam int RW = $clog2(ROWS + 1);

  logic [1:0]           state_reg;
  logic [0:ROWS*COLS-1] w_reg;
  logic [RW-1:0]        r_reg;
  logic [4:0]           c_reg;
  logic [0:ROWS*COLS-1] board_out_reg;
  logic [4:0]           lines_reg;
  logic [9:0]           total_reg;

  logic                 row_full;
  logic [0:ROWS*COLS-1] shifted;
  logic [10:0]          total_sum;
  logic [9:0]           total_next;

  row_collapse #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW)
  ) u_row_collapse (
    .w        (w_reg),
    .r        (r_reg),
    .row_full (row_full),
    .shifted  (shifted)
  );

  // Saturating running total: 11-bit sum, clamped to TOTAL_MAX
  always_comb begin
    total_sum  = {1'b0, total_reg} + {6'b0, c_reg};
    total_next = total_sum[9:0];
    if (total_sum > 11'(TOTAL_MAX)) begin
      total_next = 10'(TOTAL_MAX);
    end
  end

  // FSM, working board, row pointer, line counter and published results.
  // Results are loaded on the edge that enters DONE so they are valid in
  // the same cycle that done is high; the last test is never a shift, so
  // w_reg already holds the final board at that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      w_reg         <= '0;
      r_reg         <= '0;
      c_reg         <= '0;
      board_out_reg <= '0;
      lines_reg     <= '0;
      total_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            w_reg     <= board_in;
            r_reg     <= '0;
            c_reg     <= '0;
            state_reg <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (row_full) begin
            // Row r removed; the row that dropped into r is retested
            w_reg <= shifted;
            c_reg <= c_reg + 5'd1;
          end else begin
            r_reg <= r_reg + RW'(1);
            if (r_reg == RW'(ROWS - 1)) begin
              state_reg     <= ST_DONE;
              board_out_reg <= w_reg;
              lines_reg     <= c_reg;
              total_reg     <= total_next;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_reg == ST_SCAN);
  assign done      = (state_reg == ST_DONE);
  assign board_out = board_out_reg;
  assign lines     = lines_reg;
  assign total     = total_reg;

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: directed boards from the test plan,
// randomized boards, start-while-busy, reset abort and total saturation,
// all checked against a row-list reference model.
module tb_line_clear;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int BITS = ROWS * COLS;
  localparam int TMAX = 999;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [0:BITS-1] board_in;
  logic            busy;
  logic            done;
  logic [0:BITS-1] board_out;
  logic [4:0]      lines;
  logic [9:0]      total;

  int checks = 0;
  int errors = 0;
  int tot_model = 0;

  line_clear #(.ROWS(ROWS), .COLS(COLS), .TOTAL_MAX(TMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .board_in  (board_in),
    .busy      (busy),
    .done      (done),
    .board_out (board_out),
    .lines     (lines),
    .total     (total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: keep non-full rows in bottom-up order, pad with empty rows
  function automatic void model(input logic [0:BITS-1] b, output logic [0:BITS-1] o, output int k);
    logic [COLS-1:0] kept[$];
    logic [COLS-1:0] row;
    kept = {};
    k = 0;
    for (int rr = 0; rr < ROWS; rr++) begin
      for (int cc = 0; cc < COLS; cc++) row[cc] = b[COLS*rr + cc];
      if (row == {COLS{1'b1}}) k++;
      else kept.push_back(row);
    end
    o = '0;
    for (int rr = 0; rr < kept.size(); rr++)
      for (int cc = 0; cc < COLS; cc++) o[COLS*rr + cc] = kept[rr][cc];
  endfunction

  function automatic logic [COLS-1:0] partial_row();
    logic [COLS-1:0] v;
    v = COLS'($urandom);
    if (v == {COLS{1'b1}}) v[$urandom_range(0, COLS-1)] = 1'b0;
    return v;
  endfunction

  function automatic logic [0:BITS-1] rand_board(input int full_pct);
    logic [0:BITS-1] b;
    logic [COLS-1:0] v;
    for (int rr = 0; rr < ROWS; rr++) begin
      v = ($urandom_range(0, 99) < full_pct) ? {COLS{1'b1}} : partial_row();
      for (int cc = 0; cc < COLS; cc++) b[COLS*rr + cc] = v[cc];
    end
    return b;
  endfunction

  function automatic logic [0:BITS-1] one_line_board();
    logic [0:BITS-1] b;
    int fr;
    logic [COLS-1:0] v;
    fr = $urandom_range(0, ROWS-1);
    for (int rr = 0; rr < ROWS; rr++) begin
      v = (rr == fr) ? {COLS{1'b1}} : partial_row();
      for (int cc = 0; cc < COLS; cc++) b[COLS*rr + cc] = v[cc];
    end
    return b;
  endfunction

  // One operation: start at edge T, optionally pulse start again at cycle
  // T+restart_at, then check latency, outputs and the single done pulse.
  task automatic run_op(input string tag, input logic [0:BITS-1] b, input int restart_at);
    logic [0:BITS-1] exp_board;
    int k;
    int n;
    int extra_done;
    model(b, exp_board, k);
    tot_model = (tot_model + k > TMAX) ? TMAX : tot_model + k;
    board_in = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    board_in = rand_board(50);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      check({tag, " busy"}, BITS'(busy), BITS'(1));
      if (n == restart_at) begin
        start = 1'b1;
        board_in = rand_board(30);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, BITS'(n), BITS'(ROWS + k + 1));
    check({tag, " busy_at_done"}, BITS'(busy), BITS'(0));
    check({tag, " lines"}, BITS'(lines), BITS'(k));
    check({tag, " board"}, BITS'(board_out), BITS'(exp_board));
    check({tag, " total"}, BITS'(total), BITS'(tot_model));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, BITS'(done), BITS'(0));
    if (restart_at > 0) begin
      extra_done = 0;
      for (int i = 0; i < 45; i++) begin
        if (done === 1'b1) extra_done++;
        @(posedge clk); #1;
      end
      check({tag, " no_second_done"}, BITS'(extra_done), BITS'(0));
    end
    $display("op %s: k=%0d latency=%0d lines=%0d total=%0d", tag, k, n, lines, total);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, BITS'(busy), BITS'(0));
    check({tag, " done"}, BITS'(done), BITS'(0));
    check({tag, " board"}, BITS'(board_out), BITS'(0));
    check({tag, " lines"}, BITS'(lines), BITS'(0));
    check({tag, " total"}, BITS'(total), BITS'(0));
  endtask

  initial begin
    logic [0:BITS-1] b;
    int dcount;

    rst = 1'b1;
    start = 1'b1;
    board_in = '1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset busy", BITS'(busy), BITS'(0));

    // Empty board
    run_op("empty", '0, 0);

    // Row 0 full, row 1 holds only bit 10
    b = '0;
    for (int i = 0; i < COLS; i++) b[i] = 1'b1;
    b[10] = 1'b1;
    run_op("row0", b, 0);
    check("row0 only_bit0", BITS'(board_out), BITS'({1'b1, {(BITS-1){1'b0}}}));

    // Rows 0, 1, 3 full, row 2 = col 5 only, twice
    b = '0;
    for (int i = 0; i < COLS; i++) begin
      b[i] = 1'b1;
      b[COLS + i] = 1'b1;
      b[3*COLS + i] = 1'b1;
    end
    b[2*COLS + 5] = 1'b1;
    run_op("rows013a", b, 0);
    run_op("rows013b", b, 0);

    // Full board clears every row
    run_op("allones", '1, 0);

    // Randomized boards
    for (int t = 0; t < 24; t++) begin
      run_op($sformatf("rand%0d", t), rand_board($urandom_range(0, 60)), 0);
    end

    // start while busy is ignored
    run_op("restart", '0, 5);

    // Reset mid-operation aborts without a done pulse
    board_in = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0;
    for (int n = 1; n < 10; n++) begin
      if (done === 1'b1) dcount++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tot_model = 0;
    check_reset_outputs("abort");
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1) dcount++;
      @(posedge clk); #1;
    end
    check("abort no_done", BITS'(dcount), BITS'(0));
    $display("op abort: done pulses=%0d", dcount);

    // Bring total to 998 with single-line operations, then saturate
    for (int t = 0; t < 998; t++) begin
      run_op("single", one_line_board(), 0);
    end
    check("preload total", BITS'(total), BITS'(998));
    b = '0;
    for (int i = 0; i < 4*COLS; i++) b[i] = 1'b1;
    b[4*COLS + 2] = 1'b1;
    run_op("sat4", b, 0);
    check("sat4 total", BITS'(total), BITS'(TMAX));
    run_op("sat1", one_line_board(), 0);
    check("sat1 total", BITS'(total), BITS'(TMAX));
    check("sat1 lines", BITS'(lines), BITS'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
